// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter: FSM state encoding,
// datapath width and the round-robin winner search.
package adder_arb_pkg;

  localparam int ADD_W   = 14;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // First set bit of valid at or above ptr, wrapping at nreq. Scanning from the
  // farthest slot down lets the nearest hit overwrite earlier ones.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 nreq);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(nreq)) idx = idx - 4'(nreq);
        if (valid[idx[2:0]]) rr_pick = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/adder_14.sv
// 14-bit two's-complement adder datapath; carry-out is discarded.
module adder_14 (
  input  logic [13:0] A,
  input  logic [13:0] B,
  output logic [13:0] C
);

  assign C = A + B;

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter time-sharing one adder_14 between NREQ requesters.
// Optional signed-overflow output enabled by ADDER_SHARE_ARB_OVF_EN.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADD_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_sum
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic            rsp_ovf
`endif
);

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q, id_q, rsp_id_q, win_id;
  logic [W-1:0]         op_a_q, op_b_q, rsp_sum_q, sum_w;
  logic                 rsp_valid_q;
  logic [MAX_REQ-1:0]   valid_ext;
  logic [2:0]           win_w;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    win_w                 = rr_pick(valid_ext, 3'(rr_ptr_q), NREQ);
    win_id                = IDW'(win_w);
    req_ready             = '0;
    if (state_q == IDLE && |req_valid) req_ready[win_id] = 1'b1;
  end

  adder_14 u_adder (
    .A (op_a_q),
    .B (op_b_q),
    .C (sum_w)
  );

`ifdef ADDER_SHARE_ARB_OVF_EN
  logic rsp_ovf_q;
  assign rsp_ovf = rsp_ovf_q;
`endif

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            op_a_q   <= req_a[int'(win_id)*W +: W];
            op_b_q   <= req_b[int'(win_id)*W +: W];
            id_q     <= win_id;
            rr_ptr_q <= (int'(win_id) == NREQ - 1) ? '0 : IDW'(int'(win_id) + 1);
            state_q  <= CALC;
          end
        end
        CALC: begin
          rsp_sum_q   <= sum_w;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
`ifdef ADDER_SHARE_ARB_OVF_EN
          rsp_ovf_q   <= (op_a_q[W-1] == op_b_q[W-1]) && (sum_w[W-1] != op_a_q[W-1]);
`endif
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed, table-driven bench for adder_share_arb (optionally with ADDER_SHARE_ARB_OVF_EN).
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 14;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

`ifndef ADDER_SHARE_ARB_OVF_EN
  assign rsp_ovf = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [13:0] a;
    logic [13:0] b;
    logic [13:0] sum;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transaction from one requester with rsp_ready held high.
  task automatic run_txn(input string name, input int id, input logic [13:0] a,
                         input logic [13:0] b, input logic [13:0] esum, input logic eovf);
    int lat;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid        = 4'(1 << id);
    rsp_ready        = 1'b1;
    #1;
    check({name, " grant"}, 32'(req_ready), 32'(1 << id));
    tick();
    req_valid = '0;
    #1;
    check({name, " calc_ready"}, 32'(req_ready), 0);
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 1);
    check({name, " id"}, 32'(rsp_id), 32'(id));
    check({name, " sum"}, 32'(rsp_sum), 32'(esum));
`ifdef ADDER_SHARE_ARB_OVF_EN
    check({name, " ovf"}, 32'(rsp_ovf), 32'(eovf));
`else
    if (eovf) begin end
`endif
    tick();
    check({name, " rsp_done"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    int rsp_cnt, last_c, exp_id, lat;
    logic [13:0] exp_sum;

    vecs[0] = '{1, 14'd31,   14'h3FE1, 14'h0000, 1'b0};
    vecs[1] = '{2, 14'h3FF8, 14'h3FF7, 14'h3FEF, 1'b0};
    vecs[2] = '{2, 14'd16,   14'd8,    14'd24,   1'b0};
    vecs[3] = '{0, 14'd8191, 14'd1,    14'h2000, 1'b1};
    vecs[4] = '{3, 14'h3FF0, 14'h3FF0, 14'h3FE0, 1'b0};
    vecs[5] = '{1, 14'h3FFF, 14'h0001, 14'h0000, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_id", 32'(rsp_id), 0);
    check("reset rsp_sum", 32'(rsp_sum), 0);
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rsp_ovf", 32'(rsp_ovf), 0);
    rst = 1'b0;
    tick();
    check("idle no req", 32'(req_ready), 0);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ovf);

    // Round robin from a fresh pointer with every requester valid.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 14'(100 * i + 1);
      req_b[i*W +: W] = 14'(3 * i);
    end
    req_valid = '1; rsp_ready = 1'b1;
    rsp_cnt = 0; last_c = -1;
    for (int c = 0; c < 15; c++) begin
      check("rr onehot", 32'(req_ready & (req_ready - 4'd1)), 0);
      tick();
      if (rsp_valid) begin
        exp_id  = rsp_cnt % NREQ;
        exp_sum = 14'(100 * exp_id + 1 + 3 * exp_id);
        check($sformatf("rr id%0d", rsp_cnt), 32'(rsp_id), 32'(exp_id));
        check($sformatf("rr sum%0d", rsp_cnt), 32'(rsp_sum), 32'(exp_sum));
        if (last_c >= 0) check("rr spacing", 32'(c - last_c), 3);
        last_c = c;
        rsp_cnt++;
      end
    end
    check("rr count", 32'(rsp_cnt), 5);
    req_valid = '0;
    tick(); tick();
    check("rr drained", 32'(rsp_valid), 0);

    // Backpressure: response held while a new request waits.
    rsp_ready = 1'b0;
    req_a[2*W +: W] = 14'd5; req_b[2*W +: W] = 14'd6;
    req_valid = 4'b0100;
    #1;
    check("bp grant", 32'(req_ready), 32'h4);
    tick();
    req_a[0 +: W] = 14'd7; req_b[0 +: W] = 14'd8;
    req_valid = 4'b0001;
    tick();
    check("bp valid", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp hold valid", 32'(rsp_valid), 1);
      check("bp hold sum", 32'(rsp_sum), 11);
      check("bp hold id", 32'(rsp_id), 2);
      check("bp no ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp released", 32'(rsp_valid), 0);
    check("bp pending grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      tick();
      lat++;
    end
    check("bp next latency", 32'(lat), 1);
    check("bp next id", 32'(rsp_id), 0);
    check("bp next sum", 32'(rsp_sum), 15);
    tick();

    // Reset while a granted request is in CALC.
    req_a[1*W +: W] = 14'd3; req_b[1*W +: W] = 14'd4;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort rsp_valid", 32'(rsp_valid), 0);
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid) lat++;
    end
    check("abort no rsp", 32'(lat), 0);
    req_valid = 4'b1010;
    #1;
    check("abort ptr reset", 32'(req_ready), 32'h2);
    req_valid = '0;
    run_txn("after abort", 3, 14'd100, 14'd23, 14'd123, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
